// File: rtl/tlp_rx_decoder_pkg.sv
// Shared TLP definitions for the Host->FPGA path: fmt/type codes, header field
// positions and the receive-decoder state encoding.
package tlp_rx_decoder_pkg;

  localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
  localparam logic [2:0] FMT_4DW_NODATA = 3'b001;
  localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
  localparam logic [2:0] FMT_4DW_DATA   = 3'b011;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [9:0] LEN_ONE_DW     = 10'd1;

  // DW0 field positions
  localparam int unsigned FMT_MSB      = 32'd31;
  localparam int unsigned FMT_LSB      = 32'd29;
  localparam int unsigned FMT_DATA_BIT = 32'd30;
  localparam int unsigned FMT_4DW_BIT  = 32'd29;
  localparam int unsigned TYPE_MSB     = 32'd28;
  localparam int unsigned TYPE_LSB     = 32'd24;
  localparam int unsigned LEN_MSB      = 32'd9;
  localparam int unsigned LEN_LSB      = 32'd0;

  // DW1 field positions
  localparam int unsigned REQID_MSB    = 32'd31;
  localparam int unsigned REQID_LSB    = 32'd16;
  localparam int unsigned TAG_MSB      = 32'd15;
  localparam int unsigned TAG_LSB      = 32'd8;
  localparam int unsigned BE_MSB       = 32'd3;
  localparam int unsigned BE_LSB       = 32'd0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR2    = 3'd1,
    ST_DATA    = 3'd2,
    ST_DISCARD = 3'd3,
    ST_EMIT    = 3'd4
  } tlp_state_e;

  function automatic logic hdr_supported(input logic [2:0] fmt,
                                         input logic [4:0] typ,
                                         input logic [9:0] len);
    hdr_supported = ((fmt == FMT_3DW_NODATA) || (fmt == FMT_4DW_NODATA) ||
                     (fmt == FMT_3DW_DATA)   || (fmt == FMT_4DW_DATA)) &&
                    (typ == TYPE_MEM) && (len == LEN_ONE_DW);
  endfunction

endpackage

// File: rtl/tlp_byte_swap.sv
// Dword byte-order reversal, enabled at elaboration time.
module tlp_byte_swap #(
  parameter bit EN_SWAP = 1'b0
) (
  input  logic [31:0] dw,
  output logic [31:0] dw_swapped
);

  assign dw_swapped = EN_SWAP ? {dw[7:0], dw[15:8], dw[23:16], dw[31:24]} : dw;

endmodule

// File: rtl/tlp_rx_decoder.sv
// Host->FPGA TLP receive decoder: turns 1-DW memory read/write TLPs into single
// register requests; every other TLP is consumed, counted and discarded.
module tlp_rx_decoder
  import tlp_rx_decoder_pkg::*;
#(
  parameter bit EN_SWAP   = 1'b0,
  parameter int REG_ABITS = 6
) (
  input  logic                 pcieClk_in,
  input  logic                 pcieRstN_in,
  input  logic [63:0]          rxData_in,
  input  logic                 rxSOP_in,
  input  logic                 rxEOP_in,
  input  logic                 rxValid_in,
  output logic                 rxReady_out,
  output logic                 reqValid_out,
  input  logic                 reqReady_in,
  output logic                 reqWrite_out,
  output logic [REG_ABITS-1:0] reqAddr_out,
  output logic [31:0]          reqData_out,
  output logic [3:0]           reqBE_out,
  output logic [15:0]          reqReqID_out,
  output logic [7:0]           reqTag_out,
  output logic [15:0]          dropCount_out
);

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] HDR2    = ST_HDR2;
  localparam logic [2:0] DATA    = ST_DATA;
  localparam logic [2:0] DISCARD = ST_DISCARD;
  localparam logic [2:0] EMIT    = ST_EMIT;

  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [2:0]           beat0_nx;
  logic                 beat0_ok;
  logic                 beat0_drop;
  logic                 rx_ready;
  logic                 req_valid;
  logic                 is_write;
  logic                 is_4dw;
  logic [REG_ABITS-1:0] addr;
  logic [REG_ABITS-1:0] addr_nx;
  logic [31:0]          data;
  logic [3:0]           be;
  logic [15:0]          req_id;
  logic [7:0]           tag;
  logic [15:0]          drop_count;
  logic [16:0]          drop_sum;
  logic [1:0]           drop_inc;
  logic                 accept;
  logic                 ld_hdr;
  logic                 ld_addr;
  logic                 ld_data;
  logic                 addr_from_hi;
  logic                 data_from_hi;
  logic [31:0]          rx_lo;
  logic [31:0]          rx_hi;
  logic [31:0]          wdata_raw;
  logic [31:0]          wdata_swapped;

  assign rx_lo    = rxData_in[31:0];
  assign rx_hi    = rxData_in[63:32];
  assign accept   = rxValid_in & rx_ready;
  assign beat0_ok = hdr_supported(rx_lo[FMT_MSB:FMT_LSB], rx_lo[TYPE_MSB:TYPE_LSB],
                                  rx_lo[LEN_MSB:LEN_LSB]);

  assign wdata_raw = data_from_hi ? rx_hi : rx_lo;
  assign addr_nx   = addr_from_hi ? rx_hi[REG_ABITS+1:2] : rx_lo[REG_ABITS+1:2];
  assign drop_sum  = {1'b0, drop_count} + {15'd0, drop_inc};

  tlp_byte_swap #(.EN_SWAP(EN_SWAP)) u_swap (
    .dw         (wdata_raw),
    .dw_swapped (wdata_swapped)
  );

  // Classify a start-of-packet beat: where it leads and whether it is dropped outright.
  always_comb begin
    beat0_nx   = IDLE;
    beat0_drop = 1'b0;
    if (beat0_ok && !rxEOP_in) begin
      beat0_nx   = HDR2;
      beat0_drop = 1'b0;
    end else if (rxEOP_in) begin
      beat0_nx   = IDLE;
      beat0_drop = 1'b1;
    end else begin
      beat0_nx   = DISCARD;
      beat0_drop = 1'b1;
    end
  end

  // Next-state, field-load strobes and drop increment.
  always_comb begin
    state_nx     = state;
    drop_inc     = 2'd0;
    ld_hdr       = 1'b0;
    ld_addr      = 1'b0;
    ld_data      = 1'b0;
    addr_from_hi = 1'b0;
    data_from_hi = 1'b0;
    case (state)
      IDLE: begin
        if (accept && rxSOP_in) begin
          state_nx = beat0_nx;
          drop_inc = {1'b0, beat0_drop};
          ld_hdr   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      HDR2: begin
        if (accept && rxSOP_in) begin
          // Abandoned TLP is dropped; the new SOP beat is parsed as its own header.
          state_nx = beat0_nx;
          drop_inc = beat0_drop ? 2'd2 : 2'd1;
          ld_hdr   = 1'b1;
        end else if (accept) begin
          if (is_4dw && (rx_lo != 32'd0)) begin
            state_nx = rxEOP_in ? IDLE : DISCARD;
            drop_inc = 2'd1;
          end else begin
            ld_addr      = 1'b1;
            addr_from_hi = is_4dw;
            if (is_write && (is_4dw || !rx_lo[2])) begin
              state_nx = rxEOP_in ? IDLE : DATA;
              drop_inc = rxEOP_in ? 2'd1 : 2'd0;
            end else begin
              ld_data      = is_write;
              data_from_hi = 1'b1;
              state_nx     = rxEOP_in ? EMIT : DISCARD;
              drop_inc     = rxEOP_in ? 2'd0 : 2'd1;
            end
          end
        end else begin
          state_nx = HDR2;
        end
      end
      DATA: begin
        if (accept && rxSOP_in) begin
          state_nx = beat0_nx;
          drop_inc = beat0_drop ? 2'd2 : 2'd1;
          ld_hdr   = 1'b1;
        end else if (accept) begin
          ld_data  = 1'b1;
          state_nx = rxEOP_in ? EMIT : DISCARD;
          drop_inc = rxEOP_in ? 2'd0 : 2'd1;
        end else begin
          state_nx = DATA;
        end
      end
      DISCARD: begin
        if (accept && rxEOP_in) begin
          state_nx = IDLE;
        end else begin
          state_nx = DISCARD;
        end
      end
      EMIT: begin
        if (reqReady_in) begin
          state_nx = IDLE;
        end else begin
          state_nx = EMIT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, handshake flags, captured request fields and drop counter.
  always_ff @(posedge pcieClk_in) begin
    if (!pcieRstN_in) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      req_valid  <= 1'b0;
      is_write   <= 1'b0;
      is_4dw     <= 1'b0;
      addr       <= '0;
      data       <= 32'd0;
      be         <= 4'd0;
      req_id     <= 16'd0;
      tag        <= 8'd0;
      drop_count <= 16'd0;
    end else begin
      state     <= state_nx;
      rx_ready  <= (state_nx != EMIT);
      req_valid <= (state_nx == EMIT);
      if (ld_hdr) begin
        is_write <= rx_lo[FMT_DATA_BIT];
        is_4dw   <= rx_lo[FMT_4DW_BIT];
        req_id   <= rx_hi[REQID_MSB:REQID_LSB];
        tag      <= rx_hi[TAG_MSB:TAG_LSB];
        be       <= rx_hi[BE_MSB:BE_LSB];
        data     <= 32'd0;
      end
      if (ld_addr) begin
        addr <= addr_nx;
      end
      if (ld_data) begin
        data <= wdata_swapped;
      end
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign rxReady_out   = rx_ready;
  assign reqValid_out  = req_valid;
  assign reqWrite_out  = is_write;
  assign reqAddr_out   = addr;
  assign reqData_out   = data;
  assign reqBE_out     = be;
  assign reqReqID_out  = req_id;
  assign reqTag_out    = tag;
  assign dropCount_out = drop_count;

endmodule

// File: doc/tlp_rx_decoder.md
TLP_RX_DECODER -- requirements
Module: tlp_rx_decoder

Interface
REQ-001 SHALL have parameter EN_SWAP, default 0: 1 = byte-reverse the write-data dword before output.
REQ-002 SHALL have parameter REG_ABITS, default 6: width of the dword register address.
REQ-003 SHALL have one clock and a synchronous, active-low reset.
REQ-004 SHALL have ports, in order:
- pcieClk_in  in  1  clock
- pcieRstN_in  in  1  synchronous active-low reset
- rxData_in  in  64  Host->FPGA TLP beat; DW0 in [31:0], DW1 in [63:32]
- rxSOP_in  in  1  first beat of TLP
- rxEOP_in  in  1  last beat of TLP
- rxValid_in  in  1  beat valid
- rxReady_out  out  1  beat accepted when Valid&Ready
- reqValid_out  out  1  register request pending
- reqReady_in  in  1  request consumed when Valid&Ready
- reqWrite_out  out  1  1 = write, 0 = read
- reqAddr_out  out  REG_ABITS  dword address, TLP addr[REG_ABITS+1:2]
- reqData_out  out  32  write data; 0 for reads
- reqBE_out  out  4  first-DW byte enables
- reqReqID_out  out  16  requester ID
- reqTag_out  out  8  tag
- dropCount_out  out  16  count of discarded TLPs, saturating

Function
REQ-005 SHALL accept only 1-DW memory TLPs with length=1: fmt/type 000/00000 MRd32, 001/00000 MRd64, 010/00000 MWr32, 011/00000 MWr64.
REQ-006 SHALL decode DW0 fmt=[31:29], type=[28:24], length=[9:0]; DW1 reqID=[31:16], tag=[15:8], firstBE=[3:0].
REQ-007 SHALL implement FSM states IDLE, HDR2, DATA, DISCARD, EMIT.
REQ-008 In IDLE, a Valid&SOP beat whose header is supported and not EOP SHALL go to HDR2; any other Valid&SOP beat SHALL go to DISCARD, or stay in IDLE if EOP; Valid beats without SOP SHALL be ignored.
REQ-009 HDR2, 3DW header: address = beat[31:0]. Read -> EMIT. Write with addr[2]=1 takes data from beat[63:32] -> EMIT. Write with addr[2]=0 -> DATA.
REQ-010 HDR2, 4DW header: upper address = beat[31:0], lower address = beat[63:32]. Nonzero upper address -> DISCARD. Otherwise read -> EMIT, write -> DATA.
REQ-011 DATA SHALL take write data from beat[31:0] -> EMIT.
REQ-012 A parse that reaches EMIT without the EOP beat SHALL be discarded at the next EOP, not emitted (malformed).
REQ-013 An EOP before the parse completes SHALL discard the TLP and return to IDLE.
REQ-014 DISCARD SHALL consume beats until Valid&EOP, then go to IDLE.
REQ-015 EMIT SHALL hold reqValid_out=1 with stable outputs until reqReady_in=1, then go to IDLE on the next cycle.
REQ-016 rxReady_out SHALL be 1 in every state except EMIT, and SHALL be a registered or state-decoded signal with no combinational path from rxValid_in.
REQ-017 Latency: the first reqValid_out SHALL assert one cycle after the final accepted beat.
REQ-018 A Valid&SOP beat in HDR2 or DATA SHALL abort the current TLP, count it as dropped, and be parsed as a new beat0.
REQ-019 dropCount_out SHALL increment once per discarded TLP and saturate at 16'hFFFF.
REQ-020 With EN_SWAP=1, reqData_out SHALL be {d[7:0],d[15:8],d[23:16],d[31:24]}.

Reset
REQ-021 While pcieRstN_in=0 at a clock edge: FSM = IDLE; reqValid_out=0; rxReady_out=0; dropCount_out=0; all req* data outputs = 0.
REQ-022 rxReady_out SHALL be 1 from the first cycle after reset deasserts.
REQ-023 Reset mid-TLP or mid-EMIT SHALL abandon the transaction with no request emitted.

Structure
REQ-024 A shared package SHALL hold: fmt/type constants, a state enum, and header field-position constants. The Host->FPGA pipe and the TLP encoder will reuse it.
REQ-025 One sub-module is natural: tlp_byte_swap, a combinational dword swap selected by EN_SWAP.

Verification
REQ-026 MWr32 to addr 0x0000_0014, data 0xDEADBEEF, BE=F: 2 beats, data in beat1[63:32] -> one write, reqAddr=5, reqData=0xDEADBEEF (EN_SWAP=1: 0xEFBEADDE).
REQ-027 MRd64 to addr 0x0000_0000_0000_0008, tag 0x2A, reqID 0x0100 -> one read, reqAddr=2, reqTag=0x2A, reqReqID=0x0100, reqData=0.
REQ-028 MWr32 to addr 0x10 (qword-aligned), 3 beats -> write taken from beat2[31:0]; reqReady_in held 0 for 5 cycles -> rxReady_out=0 and outputs stable throughout.
REQ-029 Completion TLP, 4 beats, followed by an MWr with length=2 -> no request; dropCount_out=2.
REQ-030 New SOP arriving during HDR2 -> first TLP dropped (count +1), second decoded correctly; reset asserted in EMIT -> reqValid_out=0 next cycle.
REQ-031 70000 unsupported TLPs -> dropCount_out=0xFFFF.
